dark_mode_ctrl: RTL and testbench



---
 rtl/ddf_pkg.sv | 15 +
 rtl/vs_tick.sv | 42 ++++
 rtl/dark_mode_ctrl.sv | 115 +++++++++++
 tb/tb_dark_mode_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddf_pkg.sv
// Shared types and constants for the dark-mode frame controller.
package ddf_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_RISE = 2'b01,
        ST_ON   = 2'b10,
        ST_FALL = 2'b11
    } state_e;

    localparam logic [1:0] FORCE_AUTO = 2'b00;
    localparam logic [1:0] FORCE_OFF  = 2'b01;
    localparam logic [1:0] FORCE_ON   = 2'b10;

endpackage

// File: rtl/vs_tick.sv
// Vertical-sync falling-edge detector plus a LAT-cycle countdown that yields
// one sample strobe per frame; reusable by any per-frame consumer.
module vs_tick #(
    parameter int LAT = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vs_i,
    output logic strobe_o
);

    localparam int CW = $clog2(LAT + 1);

    logic          vs_q;
    logic          tick;
    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = ~vs_i & vs_q;

    // A fresh tick reloads the countdown, dropping any sample still pending.
    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = CW'(LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign strobe_o = (cnt_q == CW'(1)) & ~tick;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            vs_q  <= vs_i;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dark_mode_ctrl.sv
// Debounced, fading dark-mode inversion control: picks a target per frame
// (hysteresis or override) and ramps the blend level one step per frame.
module dark_mode_ctrl
    import ddf_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int STEP = 16,
    parameter int AW   = 8,
    parameter int LAT  = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          vs_i,
    input  logic          rx_i,
    input  logic [1:0]    force_i,
    output logic [AW-1:0] alpha_o,
    output logic          invert_o,
    output logic          busy_o,
    output logic          sample_o
);

    localparam int            CW      = $clog2(HOLD + 1);
    localparam logic [AW-1:0] MAX     = {AW{1'b1}};
    // Clamping the step to MAX keeps the AW+1-bit sum from overflowing.
    localparam logic [AW:0]   STEP_C  = (STEP >= (2**AW - 1)) ? {1'b0, MAX} : (AW+1)'(STEP);

    logic          strobe;
    logic          target_q, target_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [AW-1:0] alpha_q, alpha_d;
    logic [AW:0]   sum, diff;
    state_e        state_q, state_d;
    logic          busy_q;
    logic          sample_q;

    vs_tick #(
        .LAT(LAT)
    ) u_vs_tick (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .vs_i    (vs_i),
        .strobe_o(strobe)
    );

    // Target is settled first so the ramp below already follows a fresh flip.
    always_comb begin
        target_d = target_q;
        hold_d   = hold_q;
        case (force_i)
            FORCE_ON: begin
                target_d = 1'b1;
                hold_d   = '0;
            end
            FORCE_OFF: begin
                target_d = 1'b0;
                hold_d   = '0;
            end
            default: begin
                if (rx_i != target_q) begin
                    if (hold_q + CW'(1) == CW'(HOLD)) begin
                        target_d = ~target_q;
                        hold_d   = '0;
                    end else begin
                        hold_d = hold_q + CW'(1);
                    end
                end else begin
                    hold_d = '0;
                end
            end
        endcase

        sum     = {1'b0, alpha_q} + STEP_C;
        diff    = {1'b0, alpha_q} - STEP_C;
        alpha_d = alpha_q;
        if (target_d && alpha_q != MAX) begin
            alpha_d = (sum > {1'b0, MAX}) ? MAX : sum[AW-1:0];
        end else if (!target_d && alpha_q != '0) begin
            alpha_d = ({1'b0, alpha_q} <= STEP_C) ? '0 : diff[AW-1:0];
        end

        if (alpha_d == '0) begin
            state_d = ST_OFF;
        end else if (alpha_d == MAX) begin
            state_d = ST_ON;
        end else begin
            state_d = target_d ? ST_RISE : ST_FALL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target_q <= 1'b0;
            hold_q   <= '0;
            alpha_q  <= '0;
            state_q  <= ST_OFF;
            busy_q   <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            sample_q <= strobe;
            if (strobe) begin
                target_q <= target_d;
                hold_q   <= hold_d;
                alpha_q  <= alpha_d;
                state_q  <= state_d;
                busy_q   <= (state_d == ST_RISE) || (state_d == ST_FALL);
            end
        end
    end

    assign alpha_o  = alpha_q;
    assign invert_o = target_q;
    assign busy_o   = busy_q;
    assign sample_o = sample_q;

endmodule

// File: tb/tb_dark_mode_ctrl.sv
// Directed self-checking bench for dark_mode_ctrl (default build plus a
// narrow AW=4/STEP=5 build for saturation).
module tb_dark_mode_ctrl;
    import ddf_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       vs_i;
    logic       rx_i;
    logic [1:0] force_i;
    logic [7:0] alpha_o;
    logic       invert_o, busy_o, sample_o;
    logic [3:0] satAlpha;
    logic       satInvert, satBusy, satSample;

    int checkCount = 0;
    int passCount  = 0;

    dark_mode_ctrl dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .vs_i    (vs_i),
        .rx_i    (rx_i),
        .force_i (force_i),
        .alpha_o (alpha_o),
        .invert_o(invert_o),
        .busy_o  (busy_o),
        .sample_o(sample_o)
    );

    dark_mode_ctrl #(.HOLD(4), .STEP(5), .AW(4), .LAT(3)) satDut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .vs_i    (vs_i),
        .rx_i    (rx_i),
        .force_i (force_i),
        .alpha_o (satAlpha),
        .invert_o(satInvert),
        .busy_o  (satBusy),
        .sample_o(satSample)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyReset();
        @(negedge clk_i);
        rst_ni  = 1'b0;
        vs_i    = 1'b0;
        rx_i    = 1'b0;
        force_i = FORCE_AUTO;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // One vs pulse, then wait (bounded) for the sample pulse; lat counts
    // negedges after the falling edge, -1 on timeout.
    task automatic runFrame(input logic rxv, input logic [1:0] f, output int lat);
        @(negedge clk_i);
        vs_i    = 1'b1;
        rx_i    = rxv;
        force_i = f;
        @(negedge clk_i);
        vs_i = 1'b0;
        lat  = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            if (sample_o === 1'b1) begin
                lat = k;
                break;
            end
        end
        checkCount++;
        if (lat < 0) $display("[TB] FAIL frame_timeout: got no sample_o, expected one within 10 cycles");
        else passCount++;
    endtask

    task automatic test_reset();
        int lat;
        int seen;
        @(negedge clk_i);
        rst_ni  = 1'b0;
        rx_i    = 1'b0;
        force_i = FORCE_AUTO;
        for (int i = 0; i < 6; i++) begin
            vs_i = i[0];
            @(negedge clk_i);
        end
        checkCount++;
        if (alpha_o !== 8'd0) $display("[TB] FAIL reset_alpha: got %0d expected 0", alpha_o);
        else passCount++;
        checkCount++;
        if (invert_o !== 1'b0) $display("[TB] FAIL reset_invert: got %b expected 0", invert_o);
        else passCount++;
        checkCount++;
        if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_o);
        else passCount++;
        checkCount++;
        if (sample_o !== 1'b0) $display("[TB] FAIL reset_sample: got %b expected 0", sample_o);
        else passCount++;
        checkCount++;
        if (satAlpha !== 4'd0) $display("[TB] FAIL reset_sat_alpha: got %0d expected 0", satAlpha);
        else passCount++;

        vs_i   = 1'b0;
        rst_ni = 1'b1;
        seen   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (sample_o === 1'b1) seen++;
        end
        checkCount++;
        if (seen != 0) $display("[TB] FAIL release_no_sample: got %0d pulses expected 0", seen);
        else passCount++;

        runFrame(1'b0, FORCE_AUTO, lat);
        checkCount++;
        if (lat != 4) $display("[TB] FAIL first_tick_latency: got %0d expected 4", lat);
        else passCount++;
    endtask

    task automatic test_auto_on();
        int lat;
        logic [7:0] expA;
        logic expI, expB;
        applyReset();
        for (int n = 1; n <= 19; n++) begin
            runFrame(1'b1, FORCE_AUTO, lat);
            expA = (n < 4) ? 8'd0 : ((16 * (n - 3) > 255) ? 8'd255 : 8'(16 * (n - 3)));
            expI = (n >= 4);
            expB = (expA != 8'd0) && (expA != 8'd255);
            checkCount++;
            if (alpha_o !== expA) $display("[TB] FAIL auto_alpha[%0d]: got %0d expected %0d", n, alpha_o, expA);
            else passCount++;
            checkCount++;
            if (invert_o !== expI) $display("[TB] FAIL auto_invert[%0d]: got %b expected %b", n, invert_o, expI);
            else passCount++;
            checkCount++;
            if (busy_o !== expB) $display("[TB] FAIL auto_busy[%0d]: got %b expected %b", n, busy_o, expB);
            else passCount++;
            if (n == 4) begin
                checkCount++;
                if (lat != 4) $display("[TB] FAIL auto_latency: got %0d expected 4", lat);
                else passCount++;
            end
        end
    endtask

    task automatic test_glitch();
        int lat;
        logic [6:0] votes;
        votes = 7'b1110111;
        applyReset();
        for (int n = 0; n < 7; n++) begin
            runFrame(votes[6-n], FORCE_AUTO, lat);
            checkCount++;
            if (invert_o !== 1'b0) $display("[TB] FAIL glitch_invert[%0d]: got %b expected 0", n, invert_o);
            else passCount++;
            checkCount++;
            if (alpha_o !== 8'd0) $display("[TB] FAIL glitch_alpha[%0d]: got %0d expected 0", n, alpha_o);
            else passCount++;
        end
    endtask

    task automatic test_force();
        int lat;
        applyReset();
        for (int n = 1; n <= 4; n++) begin
            runFrame(1'b0, FORCE_ON, lat);
            checkCount++;
            if (alpha_o !== 8'(16 * n)) $display("[TB] FAIL force_on_alpha[%0d]: got %0d expected %0d", n, alpha_o, 16 * n);
            else passCount++;
            checkCount++;
            if (invert_o !== 1'b1) $display("[TB] FAIL force_on_invert[%0d]: got %b expected 1", n, invert_o);
            else passCount++;
            checkCount++;
            if (busy_o !== 1'b1) $display("[TB] FAIL force_on_busy[%0d]: got %b expected 1", n, busy_o);
            else passCount++;
        end
        runFrame(1'b1, FORCE_OFF, lat);
        checkCount++;
        if (alpha_o !== 8'd48) $display("[TB] FAIL force_off_alpha: got %0d expected 48", alpha_o);
        else passCount++;
        checkCount++;
        if (invert_o !== 1'b0) $display("[TB] FAIL force_off_invert: got %b expected 0", invert_o);
        else passCount++;
        checkCount++;
        if (busy_o !== 1'b1) $display("[TB] FAIL force_off_busy: got %b expected 1", busy_o);
        else passCount++;
        runFrame(1'b0, FORCE_AUTO, lat);
        checkCount++;
        if (alpha_o !== 8'd32 || invert_o !== 1'b0) $display("[TB] FAIL leave_force: got %0d/%b expected 32/0", alpha_o, invert_o);
        else passCount++;
        runFrame(1'b1, FORCE_AUTO, lat);
        checkCount++;
        if (alpha_o !== 8'd16 || invert_o !== 1'b0) $display("[TB] FAIL hold_after_force: got %0d/%b expected 16/0", alpha_o, invert_o);
        else passCount++;
    endtask

    task automatic test_restart();
        int pulses;
        int first;
        applyReset();
        @(negedge clk_i);
        vs_i = 1'b1;
        @(negedge clk_i);
        vs_i   = 1'b0;
        pulses = 0;
        first  = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_i);
            if (sample_o === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == 1) vs_i = 1'b1;
            if (k == 2) vs_i = 1'b0;
        end
        checkCount++;
        if (pulses != 1) $display("[TB] FAIL restart_count: got %0d expected 1", pulses);
        else passCount++;
        checkCount++;
        if (first != 6) $display("[TB] FAIL restart_time: got %0d expected 6", first);
        else passCount++;
    endtask

    task automatic test_saturation();
        int lat;
        logic [3:0] expA [8];
        logic       expB [8];
        expA = '{4'd5, 4'd10, 4'd15, 4'd15, 4'd10, 4'd5, 4'd0, 4'd0};
        expB = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        applyReset();
        for (int n = 0; n < 8; n++) begin
            runFrame(1'b0, (n < 4) ? FORCE_ON : FORCE_OFF, lat);
            checkCount++;
            if (satAlpha !== expA[n]) $display("[TB] FAIL sat_alpha[%0d]: got %0d expected %0d", n, satAlpha, expA[n]);
            else passCount++;
            checkCount++;
            if (satBusy !== expB[n]) $display("[TB] FAIL sat_busy[%0d]: got %b expected %b", n, satBusy, expB[n]);
            else passCount++;
            checkCount++;
            if (satInvert !== (n < 4)) $display("[TB] FAIL sat_invert[%0d]: got %b expected %b", n, satInvert, (n < 4));
            else passCount++;
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        vs_i    = 1'b0;
        rx_i    = 1'b0;
        force_i = FORCE_AUTO;
        test_reset();
        test_auto_on();
        test_glitch();
        test_force();
        test_restart();
        test_saturation();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
